// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter slice.
//   ST_IDLE / ST_GRANT : arbiter state encodings
//   clog2              : elaboration-time ceiling log2 used for index/counter widths
package shared_reg_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Returns at least 1 so a width derived from it is never zero.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_dff.sv
// WIDTH-bit register with load enable; holds the shared register value.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, loads RESET_VAL
//   en    : load d on the next rising edge
//   d / q : data in / registered data out
module dff_en #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   req   : per-requester write request
//   lock  : with req, ask to keep the grant after this write (bounded by MAX_BURST)
//   wdata : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt   : registered one-hot grant (zero when idle)
//   ack   : one-cycle pulse, appears together with the new q value
//   owner : index of current grantee, busy : grant active
//   q     : shared register contents
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0,
  parameter int MAX_BURST = 4,
  localparam int OW       = clog2(NREQ),
  localparam int CW       = clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [OW-1:0]         owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  logic [0:0]      state, state_n;
  logic [OW-1:0]   owner_n;
  logic [OW-1:0]   rr_ptr, rr_ptr_n;
  logic [CW-1:0]   burst_cnt, burst_cnt_n;
  logic [NREQ-1:0] ack_n;
  logic            we;
  logic [WIDTH-1:0] wsel;

  // First set bit of r scanning ptr+1 .. ptr+NREQ (mod NREQ). Caller checks |r.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [OW-1:0]   ptr);
    logic [OW-1:0] res;
    logic          found;
    int            idx;
    res   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && r[idx]) begin
        res   = idx[OW-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  logic [NREQ-1:0] own_oh, others;
  logic [CW-1:0]   cnt_inc;

  assign own_oh  = NREQ'(1) << owner;
  assign others  = req & ~own_oh;
  assign wsel    = wdata[owner*WIDTH +: WIDTH];
  assign cnt_inc = (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + CW'(1);

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    ack_n       = '0;
    we          = 1'b0;
    if (state == ST_IDLE) begin
      if (|req) begin
        state_n     = ST_GRANT;
        owner_n     = rr_pick(req, rr_ptr);
        burst_cnt_n = '0;
      end
    end else begin
      we = req[owner];
      if (we) ack_n = own_oh;
      // cnt_inc < MAX_BURST is "burst_cnt+1 < MAX_BURST" without overflow risk.
      if (we && lock[owner] && (cnt_inc < CW'(MAX_BURST))) begin
        burst_cnt_n = cnt_inc;
      end else begin
        rr_ptr_n = owner;
        if (|others) begin
          // rr_ptr becomes owner, so scan from owner+1.
          owner_n     = rr_pick(others, owner);
          burst_cnt_n = '0;
        end else if (req[owner]) begin
          // Alone and still requesting: keep owner, count keeps saturating.
          burst_cnt_n = we ? cnt_inc : burst_cnt;
        end else begin
          state_n     = ST_IDLE;
          burst_cnt_n = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= OW'(NREQ - 1);
      burst_cnt <= '0;
      ack       <= '0;
      gnt       <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
      ack       <= ack_n;
      gnt       <= (state_n == ST_GRANT) ? (NREQ'(1) << owner_n) : '0;
    end
  end

  assign busy = (state == ST_GRANT);

  dff_en #(
    .WIDTH    (WIDTH),
    .RESET_VAL(WIDTH'(RESET_VAL))
  ) u_reg (
    .clk(clk),
    .rst(reset),
    .en (we),
    .d  (wsel),
    .q  (q)
  );

endmodule
